// File: rtl/dpram_fifo_ctrl.sv
// Streaming FIFO sequencer wrapped around an external dual-port RAM with registered reads.
// Data path: accept -> RAM write -> read issue -> RD_LATENCY return pipeline -> skid buffer -> downstream.
module dpram_fifo_ctrl #(
  parameter int DATA_W     = 14,
  parameter int ADDR_W     = 18,
  parameter int DEPTH      = 262144,
  parameter int RD_LATENCY = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_rdaddress,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam int LVL_W = ADDR_W + 1;
  localparam int SK_AW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int SK_CW = $clog2(SKID_DEPTH + 1);
  localparam int OCC_W = $clog2(SKID_DEPTH + RD_LATENCY + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [SK_AW-1:0]  LAST_SKID = SK_AW'(SKID_DEPTH - 1);
  localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(DEPTH);

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [LVL_W-1:0]      avail_q, avail_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]     skid_q [SKID_DEPTH];
  logic [DATA_W-1:0]     skid_d [SKID_DEPTH];
  logic [SK_AW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [SK_CW-1:0]      cnt_q, cnt_d;
  logic                  mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0]     mem_wraddress_q, mem_wraddress_d;
  logic [ADDR_W-1:0]     mem_rdaddress_q, mem_rdaddress_d;
  logic [DATA_W-1:0]     mem_data_q, mem_data_d;

  logic                  accept, pop, capture, issue;
  logic [OCC_W-1:0]      occupancy;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [SK_AW-1:0] skid_inc(input logic [SK_AW-1:0] p);
    return (p == LAST_SKID) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = !aclr && !flush && (level_q < DEPTH_LVL);
  assign out_valid = (cnt_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign capture   = vld_q[RD_LATENCY-1];

  // Reads still in the RAM pipeline already own a skid slot, so the skid can never overflow.
  always_comb begin
    occupancy = OCC_W'(cnt_q);
    for (int i = 0; i < RD_LATENCY; i++) occupancy = occupancy + OCC_W'(vld_q[i]);
  end

  // avail_q counts only committed words, so a read never targets an address still being written.
  assign issue = !flush && (avail_q != '0) && (occupancy < OCC_W'(SKID_DEPTH));

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    avail_d         = avail_q;
    head_d          = head_q;
    tail_d          = tail_q;
    cnt_d           = cnt_q;
    skid_d          = skid_q;
    mem_wraddress_d = mem_wraddress_q;
    mem_rdaddress_d = mem_rdaddress_q;
    mem_data_d      = mem_data_q;
    mem_wren_d      = accept;
    vld_d           = vld_q << 1;
    vld_d[0]        = issue;

    if (accept) begin
      mem_wraddress_d = wr_ptr_q;
      mem_data_d      = in_data;
      wr_ptr_d        = addr_inc(wr_ptr_q);
    end
    if (issue) begin
      mem_rdaddress_d = rd_ptr_q;
      rd_ptr_d        = addr_inc(rd_ptr_q);
    end
    if (capture) begin
      skid_d[tail_q] = mem_q;
      tail_d         = skid_inc(tail_q);
    end
    if (pop) head_d = skid_inc(head_q);

    case ({capture, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    case ({accept, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    case ({mem_wren_q, issue})
      2'b10:   avail_d = avail_q + 1'b1;
      2'b01:   avail_d = avail_q - 1'b1;
      default: avail_d = avail_q;
    endcase

    // Flush drops everything, including RAM returns still in flight.
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      avail_d    = '0;
      vld_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      cnt_d      = '0;
      mem_wren_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      avail_q         <= '0;
      vld_q           <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      cnt_q           <= '0;
      mem_wren_q      <= 1'b0;
      mem_wraddress_q <= '0;
      mem_rdaddress_q <= '0;
      mem_data_q      <= '0;
      // NOTE: the skid is a handful of flops, not RAM; resetting it keeps out_data at zero after aclr.
      skid_q          <= '{default: '0};
    end else begin
      // NOTE: non-blocking updates make every register see pre-edge values, independent of statement order.
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      avail_q         <= avail_d;
      vld_q           <= vld_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      cnt_q           <= cnt_d;
      mem_wren_q      <= mem_wren_d;
      mem_wraddress_q <= mem_wraddress_d;
      mem_rdaddress_q <= mem_rdaddress_d;
      mem_data_q      <= mem_data_d;
      skid_q          <= skid_d;
    end
  end

  assign out_data      = skid_q[head_q];
  assign mem_wren      = mem_wren_q;
  assign mem_wraddress = mem_wraddress_q;
  assign mem_data      = mem_data_q;
  assign mem_rdaddress = mem_rdaddress_q;
  assign level         = level_q;
  assign full          = (level_q == DEPTH_LVL);
  assign empty         = (level_q == '0);

endmodule
